data_stack_ctrl: RTL and testbench
==================================

# data_stack_ctrl

Data-stack controller for the stack machine: holds the top two stack entries in registers and spills deeper entries to a small register-file stack. It drives the ALU's `tos`/`next`/`select` inputs and writes the ALU's `o_tos`/`o_next` results back into the stack. It sits between the instruction decoder, which issues commands, and the combinational ALU.

## Interface
Parameters:
- `WIDTH`, 16, data word width; must match the ALU.
- `DEPTH`, 16, spill-RAM entries. Maximum stack depth is `DEPTH+2`.
- `DW`, `$clog2(DEPTH+3)`, width of the depth counter (derived).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  command: 00 NOP, 01 PUSH, 10 DROP, 11 ALU.
- `cmd_sel`  in  4  ALU select code; used only when `cmd_op`=11.
- `cmd_lit`  in  WIDTH  literal for PUSH.
- `o_alu_tos`  out  WIDTH  TOS register, to the ALU `tos` input.
- `o_alu_next`  out  WIDTH  NEXT register, to the ALU `next` input.
- `o_alu_select`  out  4  `cmd_sel` when `cmd_valid` is high, `cmd_op`=11 and the state is RUN; otherwise 0000.
- `alu_tos`  in  WIDTH  ALU `o_tos` result.
- `alu_next`  in  WIDTH  ALU `o_next` result.
- `o_depth`  out  DW  current stack depth.
- `o_err`  out  1  sticky error flag.
- `o_err_code`  out  2  error cause: 00 none, 01 overflow, 10 underflow, 11 illegal select.
- `err_clr`  in  1  clears the error and returns to RUN.

## Operation
- A command is accepted when `cmd_valid & cmd_ready`. Let d be `o_depth` at acceptance.
- **Select classes:**
  - Binary: 0001, 0010, 0011, 0110, 0111, 1000, 1001, 1010, 1011. Require d≥2.
  - Unary: 1100. Requires d≥1.
  - Swap: 1101. Requires d≥2.
  - Pass: 0000. No effect; behaves as NOP.
  - Illegal: 0100, 0101, 1110, 1111.
- **NOP:** no state change.
- **PUSH:** overflow if d=DEPTH+2. Otherwise: if d≥2 then `mem[d-2]`←NEXT; NEXT←TOS; TOS←`cmd_lit`; d+1.
- **DROP:** underflow if d=0. Otherwise: TOS←NEXT; NEXT←`mem[d-3]` if d≥3, else 0; d−1.
- **Binary:** TOS←`alu_tos`; NEXT←`mem[d-3]` if d≥3, else 0; d−1.
- **Unary:** TOS←`alu_tos`; NEXT and d unchanged.
- **Swap:** TOS←`alu_tos`; NEXT←`alu_next`; d unchanged.
- **Invalid entries:** TOS/NEXT hold 0 when not backed by a valid entry after DROP or binary ops.
- **Arithmetic:** results are taken from the ALU truncated to WIDTH; the controller performs no arithmetic other than the depth ±1.
- **FSM:**
  - RUN: `cmd_ready`=1.
  - ERR: `cmd_ready`=0.
  - RUN→ERR: an accepted command fails its check. That command has no effect on TOS, NEXT, mem or depth. `o_err_code` latches the cause and `o_err`=1.
  - ERR→RUN: on `err_clr`; the error code returns to 00 and stack contents are preserved.
  - `err_clr` in RUN is ignored.
- **Check priority:** illegal select is checked before underflow.

## Timing
- **Reset (async assert):** TOS=0, NEXT=0, depth=0, state RUN, `o_err`=0, `o_err_code`=00, `cmd_ready`=1. The mem array is not reset.
- **Latency:** single-cycle. Results are visible on the outputs in the cycle after the accepting edge, so back-to-back commands are allowed every cycle in RUN.
- **ALU path:** combinational within the accepting cycle: `o_alu_*` → ALU → `alu_*` → register D inputs.
- **Errors:** `o_err` rises the cycle after the failing command. `cmd_ready` is low from that cycle until the cycle after `err_clr` is sampled.
- **Spill RAM:** a write and a read of different addresses never coincide in one command. Read is asynchronous; write is on the clock edge.
- **Reset mid-operation:** reset during any state returns immediately to the reset values. An in-flight command is discarded.

## Structure
- Package `stack_pkg` holds:
  - cmd_op constants: OP_NOP, OP_PUSH, OP_DROP, OP_ALU.
  - ALU select constants: SEL_PASS, SEL_ADD … SEL_SWAP.
  - Error codes: ERR_NONE, ERR_OVF, ERR_UNF, ERR_ILL.
  - FSM state enum: ST_RUN, ST_ERR.
  - Select classifier function returning binary/unary/swap/pass/illegal.
- Sub-module `stack_ram`: DEPTH×WIDTH register file with one synchronous write port and one asynchronous read port. It has no reset.

## Test plan
- Reset, PUSH 3, PUSH 5, ALU 0001 → `o_alu_tos`=8, `o_depth`=1, `o_alu_next`=0.
- PUSH 7, PUSH 2, ALU 1101 → TOS=7, NEXT=2, depth 2. Then ALU 1010 (tos>next) → TOS=0xFFFF, depth 1.
- PUSH 1..18, DROP ×18 → TOS sequence 18,17,…,1, then depth 0. A 19th PUSH after refilling → `o_err`=1, code 01, depth stays 18, `cmd_ready`=0. `err_clr` → `cmd_ready`=1 with TOS=18 intact.
- depth 1, ALU 0010 → code 10 and TOS unchanged. depth 0, DROP → code 10. depth 0, ALU 1100 → code 10.
- depth 2, ALU 0101 → code 11 (illegal beats underflow on depth 0 too), `o_alu_select`=0101 during the attempt, stack unchanged.
- Assert `rst_n` low mid-stream with depth 5 and in ERR → outputs return to reset values asynchronously, and the first PUSH after release is accepted.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants, FSM state type and ALU select classifier for the data stack.
package stack_pkg;

   // Decoder command opcodes
   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_DROP = 2'b10;
   localparam logic [1:0] OP_ALU  = 2'b11;

   // ALU select codes
   localparam logic [3:0] SEL_PASS = 4'h0;
   localparam logic [3:0] SEL_ADD  = 4'h1;
   localparam logic [3:0] SEL_SUB  = 4'h2;
   localparam logic [3:0] SEL_AND  = 4'h3;
   localparam logic [3:0] SEL_OR   = 4'h6;
   localparam logic [3:0] SEL_XOR  = 4'h7;
   localparam logic [3:0] SEL_SHL  = 4'h8;
   localparam logic [3:0] SEL_SHR  = 4'h9;
   localparam logic [3:0] SEL_GT   = 4'hA;
   localparam logic [3:0] SEL_EQ   = 4'hB;
   localparam logic [3:0] SEL_NOT  = 4'hC;
   localparam logic [3:0] SEL_SWAP = 4'hD;

   // Error causes
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UNF  = 2'b10;
   localparam logic [1:0] ERR_ILL  = 2'b11;

   typedef enum logic {ST_RUN, ST_ERR} state_t;

   typedef enum logic [2:0] {CLS_PASS, CLS_BIN, CLS_UNA, CLS_SWAP, CLS_ILL} sel_class_t;

   // Map a select code to the stack effect it has
   function automatic sel_class_t classify_sel(input logic [3:0] sel);
      sel_class_t cls;
      case (sel)
         SEL_PASS: cls = CLS_PASS;
         SEL_ADD, SEL_SUB, SEL_AND, SEL_OR, SEL_XOR,
         SEL_SHL, SEL_SHR, SEL_GT, SEL_EQ: cls = CLS_BIN;
         SEL_NOT:  cls = CLS_UNA;
         SEL_SWAP: cls = CLS_SWAP;
         default:  cls = CLS_ILL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/stack_ram.sv
// Spill storage for stack entries below NEXT: one clocked write port, one
// asynchronous read port, no reset.
module stack_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port updates on the rising edge only
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack_ctrl.sv
// Data-stack controller: TOS/NEXT in registers, deeper entries spilled to
// stack_ram. Feeds the combinational ALU and writes its results back.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high exactly in RUN, and the
// decoder holds cmd_op/cmd_sel/cmd_lit stable while cmd_valid is high.
module data_stack_ctrl
   import stack_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int DW    = $clog2(DEPTH+3)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_sel,
   input  logic [WIDTH-1:0] cmd_lit,
   output logic [WIDTH-1:0] o_alu_tos,
   output logic [WIDTH-1:0] o_alu_next,
   output logic [3:0]       o_alu_select,
   input  logic [WIDTH-1:0] alu_tos,
   input  logic [WIDTH-1:0] alu_next,
   output logic [DW-1:0]    o_depth,
   output logic             o_err,
   output logic [1:0]       o_err_code,
   input  logic             err_clr
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DW-1:0] MAX_DEPTH = DW'(DEPTH + 2);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] tos, tos_nxt;
   logic [WIDTH-1:0] nos, nos_nxt;
   logic [DW-1:0]    depth, depth_nxt;
   logic [1:0]       err_code, err_code_nxt;
   logic             ram_we;
   logic [AW-1:0]    ram_waddr, ram_raddr;
   logic [WIDTH-1:0] ram_rdata;
   logic [WIDTH-1:0] refill;
   logic             accept;
   sel_class_t       sel_cls;

   // Entry that becomes NEXT when the stack shrinks: mem[d-3], or 0 if none
   assign ram_waddr = AW'(depth - DW'(2));
   assign ram_raddr = AW'(depth - DW'(3));
   assign refill    = (depth >= DW'(3)) ? ram_rdata : '0;

   assign accept    = cmd_valid && (state == ST_RUN);
   assign sel_cls   = classify_sel(cmd_sel);

   assign cmd_ready    = (state == ST_RUN);
   assign o_alu_tos    = tos;
   assign o_alu_next   = nos;
   assign o_alu_select = (accept && cmd_op == OP_ALU) ? cmd_sel : 4'b0000;
   assign o_depth      = depth;
   assign o_err        = (state == ST_ERR);
   assign o_err_code   = err_code;

   stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (nos),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // State, stack registers and error code update on the rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         tos      <= '0;
         nos      <= '0;
         depth    <= '0;
         err_code <= ERR_NONE;
      end else begin
         state    <= state_nxt;
         tos      <= tos_nxt;
         nos      <= nos_nxt;
         depth    <= depth_nxt;
         err_code <= err_code_nxt;
      end
   end

   // Command checks and stack effects; a failing command changes nothing but the FSM
   always_comb begin
      state_nxt    = state;
      tos_nxt      = tos;
      nos_nxt      = nos;
      depth_nxt    = depth;
      err_code_nxt = err_code;
      ram_we       = 1'b0;
      case (state)
         ST_RUN: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_PUSH: begin
                     if (depth == MAX_DEPTH) begin
                        state_nxt    = ST_ERR;
                        err_code_nxt = ERR_OVF;
                     end else begin
                        ram_we    = (depth >= DW'(2));
                        nos_nxt   = tos;
                        tos_nxt   = cmd_lit;
                        depth_nxt = depth + DW'(1);
                     end
                  end
                  OP_DROP: begin
                     if (depth == '0) begin
                        state_nxt    = ST_ERR;
                        err_code_nxt = ERR_UNF;
                     end else begin
                        tos_nxt   = nos;
                        nos_nxt   = refill;
                        depth_nxt = depth - DW'(1);
                     end
                  end
                  OP_ALU: begin
                     case (sel_cls)
                        CLS_ILL: begin
                           state_nxt    = ST_ERR;
                           err_code_nxt = ERR_ILL;
                        end
                        CLS_BIN: begin
                           if (depth < DW'(2)) begin
                              state_nxt    = ST_ERR;
                              err_code_nxt = ERR_UNF;
                           end else begin
                              tos_nxt   = alu_tos;
                              nos_nxt   = refill;
                              depth_nxt = depth - DW'(1);
                           end
                        end
                        CLS_UNA: begin
                           if (depth == '0) begin
                              state_nxt    = ST_ERR;
                              err_code_nxt = ERR_UNF;
                           end else begin
                              tos_nxt = alu_tos;
                           end
                        end
                        CLS_SWAP: begin
                           if (depth < DW'(2)) begin
                              state_nxt    = ST_ERR;
                              err_code_nxt = ERR_UNF;
                           end else begin
                              tos_nxt = alu_tos;
                              nos_nxt = alu_next;
                           end
                        end
                        default: ;
                     endcase
                  end
                  default: ;
               endcase
            end
         end
         ST_ERR: begin
            if (err_clr) begin
               state_nxt    = ST_RUN;
               err_code_nxt = ERR_NONE;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

endmodule

// File: tb/tb_data_stack_ctrl.sv
// Bench for data_stack_ctrl: directed scenarios plus random commands checked
// against a queue-based stack model, with a behavioural ALU in the loop.
module tb_data_stack_ctrl;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int DW    = $clog2(DEPTH+3);
   localparam int MAXD  = DEPTH + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [3:0]       cmd_sel = 4'h0;
   logic [WIDTH-1:0] cmd_lit = '0;
   logic [WIDTH-1:0] o_alu_tos, o_alu_next;
   logic [3:0]       o_alu_select;
   logic [WIDTH-1:0] alu_tos, alu_next;
   logic [DW-1:0]    o_depth;
   logic             o_err;
   logic [1:0]       o_err_code;
   logic             err_clr = 1'b0;

   data_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_sel      (cmd_sel),
      .cmd_lit      (cmd_lit),
      .o_alu_tos    (o_alu_tos),
      .o_alu_next   (o_alu_next),
      .o_alu_select (o_alu_select),
      .alu_tos      (alu_tos),
      .alu_next     (alu_next),
      .o_depth      (o_depth),
      .o_err        (o_err),
      .o_err_code   (o_err_code),
      .err_clr      (err_clr)
   );

   // Behavioural ALU: returns {next_result, tos_result}
   function automatic logic [2*WIDTH-1:0] alu_fn(input logic [3:0] sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] t, n;
      t = a;
      n = b;
      case (sel)
         4'h1: t = a + b;
         4'h2: t = a - b;
         4'h3: t = a & b;
         4'h6: t = a | b;
         4'h7: t = a ^ b;
         4'h8: t = b << a[3:0];
         4'h9: t = b >> a[3:0];
         4'hA: t = (a > b) ? '1 : '0;
         4'hB: t = (a == b) ? '1 : '0;
         4'hC: t = ~a;
         4'hD: begin t = b; n = a; end
         default: ;
      endcase
      return {n, t};
   endfunction

   always_comb {alu_next, alu_tos} = alu_fn(o_alu_select, o_alu_tos, o_alu_next);

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] exp_q[$];   // stack contents, top at the back
   logic             m_err = 1'b0;
   logic [1:0]       m_code = 2'b00;

   function automatic logic [WIDTH-1:0] m_tos();
      return (exp_q.size() >= 1) ? exp_q[exp_q.size()-1] : '0;
   endfunction

   function automatic logic [WIDTH-1:0] m_next();
      return (exp_q.size() >= 2) ? exp_q[exp_q.size()-2] : '0;
   endfunction

   task automatic model_step(input logic v, input logic [1:0] op, input logic [3:0] sel,
                             input logic [WIDTH-1:0] lit, input logic clr);
      int d;
      logic [WIDTH-1:0] at, an;
      logic [1:0] cause;
      d = exp_q.size();
      {an, at} = alu_fn(sel, m_tos(), m_next());
      cause = 2'b00;
      if (m_err) begin
         if (clr) begin
            m_err  = 1'b0;
            m_code = 2'b00;
         end
      end else if (v) begin
         case (op)
            2'b01: if (d == MAXD) cause = 2'b01; else exp_q.push_back(lit);
            2'b10: if (d == 0) cause = 2'b10; else void'(exp_q.pop_back());
            2'b11: begin
               if (sel inside {4'h4, 4'h5, 4'hE, 4'hF}) cause = 2'b11;
               else if (sel == 4'h0) ;
               else if (sel == 4'hC) begin
                  if (d < 1) cause = 2'b10; else exp_q[d-1] = at;
               end else if (sel == 4'hD) begin
                  if (d < 2) cause = 2'b10;
                  else begin exp_q[d-1] = at; exp_q[d-2] = an; end
               end else begin
                  if (d < 2) cause = 2'b10;
                  else begin
                     void'(exp_q.pop_back());
                     void'(exp_q.pop_back());
                     exp_q.push_back(at);
                  end
               end
            end
            default: ;
         endcase
         if (cause != 2'b00) begin
            m_err  = 1'b1;
            m_code = cause;
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".tos"},   32'(o_alu_tos),  32'(m_tos()));
      check_val({tag, ".next"},  32'(o_alu_next), 32'(m_next()));
      check_val({tag, ".depth"}, 32'(o_depth),    32'(exp_q.size()));
      check_val({tag, ".err"},   32'(o_err),      32'(m_err));
      check_val({tag, ".code"},  32'(o_err_code), 32'(m_code));
      check_val({tag, ".ready"}, 32'(cmd_ready),  32'(!m_err));
   endtask

   // ---------------- driver tasks ----------------
   // Called at posedge+1; drives one cycle and checks the registered result.
   task automatic apply(input string tag, input logic v, input logic [1:0] op,
                        input logic [3:0] sel, input logic [WIDTH-1:0] lit, input logic clr);
      logic [3:0] exp_sel;
      cmd_valid = v;
      cmd_op    = op;
      cmd_sel   = sel;
      cmd_lit   = lit;
      err_clr   = clr;
      #1;
      exp_sel = (v && op == 2'b11 && !m_err) ? sel : 4'h0;
      check_val({tag, ".select"}, 32'(o_alu_select), 32'(exp_sel));
      @(posedge clk);
      model_step(v, op, sel, lit, clr);
      #1;
      cmd_valid = 1'b0;
      err_clr   = 1'b0;
      check_outputs(tag);
   endtask

   task automatic push(input logic [WIDTH-1:0] lit);
      apply("push", 1'b1, 2'b01, 4'h0, lit, 1'b0);
   endtask

   task automatic drop();
      apply("drop", 1'b1, 2'b10, 4'h0, '0, 1'b0);
   endtask

   task automatic alu(input logic [3:0] sel);
      apply("alu", 1'b1, 2'b11, sel, '0, 1'b0);
   endtask

   task automatic clear();
      apply("clr", 1'b0, 2'b00, 4'h0, '0, 1'b1);
   endtask

   // Asynchronous reset mid-cycle, with a command still on the bus
   task automatic do_reset(input string tag);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_lit   = 16'hDEAD;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      m_err  = 1'b0;
      m_code = 2'b00;
      check_outputs(tag);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #12;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // add
      push(16'd3);
      push(16'd5);
      alu(4'h1);
      check_val("plan_add_tos", 32'(o_alu_tos), 32'd8);
      check_val("plan_add_depth", 32'(o_depth), 32'd1);
      check_val("plan_add_next", 32'(o_alu_next), 32'd0);
      drop();

      // swap then compare
      push(16'd7);
      push(16'd2);
      alu(4'hD);
      check_val("plan_swap_tos", 32'(o_alu_tos), 32'd7);
      check_val("plan_swap_next", 32'(o_alu_next), 32'd2);
      check_val("plan_swap_depth", 32'(o_depth), 32'd2);
      alu(4'hA);
      check_val("plan_gt_tos", 32'(o_alu_tos), 32'hFFFF);
      check_val("plan_gt_depth", 32'(o_depth), 32'd1);

      // fill, drain, overflow
      do_reset("rst1");
      for (int i = 1; i <= MAXD; i++) push(WIDTH'(i));
      for (int i = MAXD; i >= 1; i--) begin
         check_val("drain_tos", 32'(o_alu_tos), 32'(i));
         drop();
      end
      check_val("drain_depth", 32'(o_depth), 32'd0);
      for (int i = 1; i <= MAXD; i++) push(WIDTH'(i));
      push(16'd19);
      check_val("ovf_err", 32'(o_err), 32'd1);
      check_val("ovf_code", 32'(o_err_code), 32'd1);
      check_val("ovf_depth", 32'(o_depth), 32'(MAXD));
      check_val("ovf_ready", 32'(cmd_ready), 32'd0);
      clear();
      check_val("clr_ready", 32'(cmd_ready), 32'd1);
      check_val("clr_tos", 32'(o_alu_tos), 32'd18);

      // underflow and illegal select
      do_reset("rst2");
      push(16'd9);
      alu(4'h2);
      check_val("unf_bin_code", 32'(o_err_code), 32'd2);
      check_val("unf_bin_tos", 32'(o_alu_tos), 32'd9);
      clear();
      drop();
      drop();
      check_val("unf_drop_code", 32'(o_err_code), 32'd2);
      clear();
      alu(4'hC);
      check_val("unf_una_code", 32'(o_err_code), 32'd2);
      clear();
      alu(4'h5);
      check_val("ill_empty_code", 32'(o_err_code), 32'd3);
      clear();
      push(16'h1234);
      push(16'h5678);
      alu(4'h5);
      check_val("ill_code", 32'(o_err_code), 32'd3);
      check_val("ill_tos", 32'(o_alu_tos), 32'h5678);
      clear();

      // random commands against the model
      for (int n = 0; n < 700; n++) begin
         int r;
         logic v, clr;
         logic [1:0] op;
         r   = $urandom_range(0, 9);
         op  = (r == 0) ? 2'b00 : (r <= 4) ? 2'b01 : (r <= 6) ? 2'b10 : 2'b11;
         v   = ($urandom_range(0, 3) != 0);
         clr = m_err ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
         apply("rnd", v, op, 4'($urandom_range(0, 15)), WIDTH'($urandom), clr);
      end

      // reset in ERR at depth 5, then first PUSH after release
      do_reset("rst3");
      for (int i = 0; i < 5; i++) push(WIDTH'($urandom));
      alu(4'hE);
      check_val("pre_rst_err", 32'(o_err), 32'd1);
      check_val("pre_rst_depth", 32'(o_depth), 32'd5);
      do_reset("rst_mid");
      push(16'hBEEF);
      check_val("post_rst_tos", 32'(o_alu_tos), 32'hBEEF);
      check_val("post_rst_depth", 32'(o_depth), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
